// File: rtl/ecap5_dproc_pkg.sv
// Shared Wishbone widths and a byte-lane merge helper for the data-side bus slaves.
package ecap5_dproc_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  function automatic logic [WB_DAT_W-1:0] merge_lanes(
    input logic [WB_DAT_W-1:0] old_word,
    input logic [WB_DAT_W-1:0] new_word,
    input logic [WB_SEL_W-1:0] sel
  );
    logic [WB_DAT_W-1:0] word;
    word = old_word;
    for (int b = 0; b < WB_SEL_W; b++) begin
      if (sel[b]) begin
        word[8*b +: 8] = new_word[8*b +: 8];
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/wb_req_queue.sv
// Circular request queue; every entry carries a wait counter that ages each cycle
// so the head becomes ready LATENCY cycles after it was pushed.
module wb_req_queue #(
  parameter int WIDTH   = 44,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_ready,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);
  localparam logic [2:0]  WAIT_LOAD  = 3'(LATENCY);

  logic [WIDTH-1:0] data [DEPTH];
  logic [2:0]       wait_cnt [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW:0]      count;

  assign head_data  = data[head];
  assign head_ready = (count != '0) && (wait_cnt[head] == 3'd0);
  assign full       = (count == FULL_COUNT);

  // Payload storage needs no reset: only entries inside the count window are read.
  always_ff @(posedge clk) begin
    if (push) begin
      data[tail] <= push_data;
    end
  end

  // Pointers, occupancy and per-entry wait counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        wait_cnt[i] <= 3'd0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        wait_cnt[i] <= 3'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wait_cnt[i] != 3'd0) begin
          wait_cnt[i] <= wait_cnt[i] - 3'd1;
        end
      end
      // The freshly pushed slot overrides the ageing update above.
      if (push) begin
        wait_cnt[tail] <= WAIT_LOAD;
        tail           <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_slave_mem.sv
// Pipelined Wishbone word memory: requests are queued, aged LATENCY cycles,
// then serviced in order with a one-cycle registered ack.
module wb_slave_mem
  import ecap5_dproc_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int LATENCY     = 1,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [WB_ADR_W-1:0] wb_adr_i,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  input  logic                wb_we_i,
  input  logic [WB_SEL_W-1:0] wb_sel_i,
  input  logic                wb_stb_i,
  output logic                wb_ack_o,
  input  logic                wb_cyc_i,
  output logic                wb_stall_o
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0]       idx;
    logic [WB_DAT_W-1:0] dat;
    logic                we;
    logic [WB_SEL_W-1:0] sel;
  } req_t;

  req_t                push_req;
  req_t                head_req;
  logic                push;
  logic                pop;
  logic                head_ready;
  logic                full;
  logic [WB_DAT_W-1:0] mem [DEPTH];
  logic                unused_adr;

  // Byte offset and bits above the memory window are don't-care: addresses wrap.
  assign unused_adr = ^{wb_adr_i[WB_ADR_W-1:AW+2], wb_adr_i[1:0]};

  assign push_req   = '{idx: wb_adr_i[AW+1:2], dat: wb_dat_i, we: wb_we_i, sel: wb_sel_i};
  assign push       = wb_cyc_i & wb_stb_i & ~full;
  assign pop        = wb_cyc_i & head_ready;
  assign wb_stall_o = full;

  wb_req_queue #(
    .WIDTH  ($bits(req_t)),
    .DEPTH  (QUEUE_DEPTH),
    .LATENCY(LATENCY)
  ) u_queue (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (~wb_cyc_i),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .head_data (head_req),
    .head_ready(head_ready),
    .full      (full)
  );

  // Memory array is deliberately left out of reset; writes commit when serviced.
  always_ff @(posedge clk_i) begin
    if (pop && head_req.we) begin
      mem[head_req.idx] <= merge_lanes(mem[head_req.idx], head_req.dat, head_req.sel);
    end
  end

  // Registered response: data only for read acks, zero otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= pop;
      wb_dat_o <= (pop && !head_req.we) ? mem[head_req.idx] : '0;
    end
  end

endmodule

// File: tb/tb_wb_slave_mem.sv
// Bench for wb_slave_mem: three instances (LATENCY 1/7/3) driven from a vector table
// and hand sequences, with a per-instance scoreboard of expected ack data and ack edge.
module tb_wb_slave_mem;

  typedef struct {
    logic [31:0] dat;
    int          edge_n;
  } exp_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic [31:0] adr   [3];
  logic [31:0] dat_i [3];
  logic [31:0] dat_o [3];
  logic        we    [3];
  logic [3:0]  sel   [3];
  logic        stb   [3];
  logic        cyc   [3];
  logic        ack   [3];
  logic        stall [3];

  int   lat [3] = '{1, 7, 3};
  int   edge_n = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   ack_cnt [3] = '{0, 0, 0};
  int   last_exp [3] = '{0, 0, 0};
  exp_t sbq [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  wb_slave_mem #(.DEPTH(1024), .LATENCY(1), .QUEUE_DEPTH(4)) dut_a (
    .clk_i(clk), .rst_i(rst[0]), .wb_adr_i(adr[0]), .wb_dat_i(dat_i[0]), .wb_dat_o(dat_o[0]),
    .wb_we_i(we[0]), .wb_sel_i(sel[0]), .wb_stb_i(stb[0]), .wb_ack_o(ack[0]),
    .wb_cyc_i(cyc[0]), .wb_stall_o(stall[0]));

  wb_slave_mem #(.DEPTH(1024), .LATENCY(7), .QUEUE_DEPTH(4)) dut_b (
    .clk_i(clk), .rst_i(rst[1]), .wb_adr_i(adr[1]), .wb_dat_i(dat_i[1]), .wb_dat_o(dat_o[1]),
    .wb_we_i(we[1]), .wb_sel_i(sel[1]), .wb_stb_i(stb[1]), .wb_ack_o(ack[1]),
    .wb_cyc_i(cyc[1]), .wb_stall_o(stall[1]));

  wb_slave_mem #(.DEPTH(1024), .LATENCY(3), .QUEUE_DEPTH(4)) dut_c (
    .clk_i(clk), .rst_i(rst[2]), .wb_adr_i(adr[2]), .wb_dat_i(dat_i[2]), .wb_dat_o(dat_o[2]),
    .wb_we_i(we[2]), .wb_sel_i(sel[2]), .wb_stb_i(stb[2]), .wb_ack_o(ack[2]),
    .wb_cyc_i(cyc[2]), .wb_stall_o(stall[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard: every ack must match the oldest expectation in data and in edge number.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ack[d] === 1'b1) begin
        ack_cnt[d]++;
        if (sbq[d].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack dut%0d: got ack at edge %0d, expected none", d, edge_n);
        end else begin
          exp_t e;
          e = sbq[d].pop_front();
          check($sformatf("ack_data dut%0d", d), dat_o[d], e.dat);
          check($sformatf("ack_edge dut%0d", d), edge_n, e.edge_n);
        end
      end else begin
        check($sformatf("idle_dat dut%0d", d), dat_o[d], 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge following acceptance with stb dropped.
  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] wd, input logic w,
                       input logic [3:0] s, input logic [31:0] exp_rd, input bit track);
    int   waited;
    int   acc;
    exp_t e;
    waited = 0;
    cyc[d] = 1'b1; stb[d] = 1'b1; adr[d] = a; dat_i[d] = wd; we[d] = w; sel[d] = s;
    while (stall[d] === 1'b1 && waited < 50) begin
      @(posedge clk); @(negedge clk);
      waited++;
    end
    if (stall[d] === 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL stall_timeout dut%0d: adr %h still stalled after %0d cycles, expected accept", d, a, waited);
      stb[d] = 1'b0;
      return;
    end
    if (track) begin
      acc = edge_n + 1;
      e.dat = w ? 32'd0 : exp_rd;
      e.edge_n = (acc + 1 + lat[d] > last_exp[d] + 1) ? acc + 1 + lat[d] : last_exp[d] + 1;
      last_exp[d] = e.edge_n;
      sbq[d].push_back(e);
    end
    @(posedge clk); @(negedge clk);
    stb[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (sbq[d].size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("pending_acks dut%0d", d), sbq[d].size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t tbl [14];
    int   base;
    tbl[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 4'b1111, 32'h0};
    tbl[1]  = '{32'h0000_0010, 32'h0,         1'b0, 4'b1111, 32'hDEAD_BEEF};
    tbl[2]  = '{32'h0000_0020, 32'h0,         1'b1, 4'b1111, 32'h0};
    tbl[3]  = '{32'h0000_0020, 32'h1122_3344, 1'b1, 4'b0101, 32'h0};
    tbl[4]  = '{32'h0000_0020, 32'h0,         1'b0, 4'b1111, 32'h0022_0044};
    tbl[5]  = '{32'h0000_1000, 32'hA5A5_A5A5, 1'b1, 4'b1111, 32'h0};
    tbl[6]  = '{32'h0000_0000, 32'h0,         1'b0, 4'b1111, 32'hA5A5_A5A5};
    tbl[7]  = '{32'h0000_0024, 32'hCAFE_F00D, 1'b1, 4'b1111, 32'h0};
    tbl[8]  = '{32'h0000_0024, 32'hFFFF_FFFF, 1'b1, 4'b0000, 32'h0};
    tbl[9]  = '{32'h0000_0027, 32'h0,         1'b0, 4'b0000, 32'hCAFE_F00D};
    tbl[10] = '{32'h0000_0028, 32'h0,         1'b1, 4'b1111, 32'h0};
    tbl[11] = '{32'h0000_0028, 32'hAABB_CCDD, 1'b1, 4'b1000, 32'h0};
    tbl[12] = '{32'h0000_002B, 32'h0000_00EE, 1'b1, 4'b0001, 32'h0};
    tbl[13] = '{32'hFFFF_F028, 32'h0,         1'b0, 4'b0010, 32'hAA00_00EE};

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0;
      adr[d] = 32'h0; dat_i[d] = 32'h0; we[d] = 1'b0; sel[d] = 4'h0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_ack dut%0d", d), {31'd0, ack[d]}, 32'd0);
      check($sformatf("reset_stall dut%0d", d), {31'd0, stall[d]}, 32'd0);
      rst[d] = 1'b0;
      cyc[d] = 1'b1;
    end

    // Table vectors back to back on the LATENCY=1 instance, starting right after reset.
    for (int i = 0; i < 14; i++) begin
      issue(0, tbl[i].adr, tbl[i].wdat, tbl[i].we, tbl[i].sel, tbl[i].exp_rd, 1'b1);
    end
    drain(0);

    // Queue full with LATENCY=7: stall after the 4th acceptance, then the rest drain in.
    issue(1, 32'h0, 32'h1111_1111, 1'b1, 4'hF, 32'h0, 1'b1);
    issue(1, 32'h4, 32'h2222_2222, 1'b1, 4'hF, 32'h0, 1'b1);
    issue(1, 32'h8, 32'h3333_3333, 1'b1, 4'hF, 32'h0, 1'b1);
    issue(1, 32'hC, 32'h4444_4444, 1'b1, 4'hF, 32'h0, 1'b1);
    check("stall_after_4", {31'd0, stall[1]}, 32'd1);
    issue(1, 32'h0, 32'h0, 1'b0, 4'hF, 32'h1111_1111, 1'b1);
    issue(1, 32'hC, 32'h0, 1'b0, 4'hF, 32'h4444_4444, 1'b1);
    drain(1);
    check("total_acks dut1", ack_cnt[1], 32'd6);

    // Flush with LATENCY=3: queued writes vanish, prior contents survive.
    issue(2, 32'h40, 32'h0101_0101, 1'b1, 4'hF, 32'h0, 1'b1);
    issue(2, 32'h44, 32'h0202_0202, 1'b1, 4'hF, 32'h0, 1'b1);
    issue(2, 32'h48, 32'h0303_0303, 1'b1, 4'hF, 32'h0, 1'b1);
    drain(2);
    base = ack_cnt[2];
    issue(2, 32'h40, 32'hBAD0_0001, 1'b1, 4'hF, 32'h0, 1'b0);
    issue(2, 32'h44, 32'hBAD0_0002, 1'b1, 4'hF, 32'h0, 1'b0);
    issue(2, 32'h48, 32'hBAD0_0003, 1'b1, 4'hF, 32'h0, 1'b0);
    cyc[2] = 1'b0;
    @(negedge clk);
    cyc[2] = 1'b1;
    repeat (12) @(negedge clk);
    check("flush_acks dut2", ack_cnt[2] - base, 32'd0);
    issue(2, 32'h40, 32'h0, 1'b0, 4'hF, 32'h0101_0101, 1'b1);
    issue(2, 32'h44, 32'h0, 1'b0, 4'hF, 32'h0202_0202, 1'b1);
    issue(2, 32'h48, 32'h0, 1'b0, 4'hF, 32'h0303_0303, 1'b1);
    drain(2);

    // Reset with two reads outstanding: ack drops at once, nothing leaks out afterwards.
    issue(0, 32'h10, 32'h0, 1'b0, 4'hF, 32'h0, 1'b0);
    issue(0, 32'h20, 32'h0, 1'b0, 4'hF, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("ack_before_rst", {31'd0, ack[0]}, 32'd1);
    rst[0] = 1'b1;
    #1;
    check("rst_ack", {31'd0, ack[0]}, 32'd0);
    check("rst_dat", dat_o[0], 32'd0);
    check("rst_stall", {31'd0, stall[0]}, 32'd0);
    base = ack_cnt[0];
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_acks", ack_cnt[0] - base, 32'd0);
    check("post_rst_stall", {31'd0, stall[0]}, 32'd0);
    issue(0, 32'h10, 32'h0, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b1);
    drain(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_slave_mem.md
WB_SLAVE_MEM -- requirements
Module: wb_slave_mem

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning memory size in 32-bit words (power of 2).
REQ-002 The block SHALL have parameter LATENCY, default 1, meaning extra wait cycles between request acceptance and ack (0..7).
REQ-003 The block SHALL have parameter QUEUE_DEPTH, default 4, meaning maximum outstanding accepted requests (power of 2, >=2).
REQ-004 The block SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port wb_adr_i  input  32  byte address.
REQ-007 The block SHALL have port wb_dat_i  input  32  write data.
REQ-008 The block SHALL have port wb_dat_o  output  32  read data, valid with ack.
REQ-009 The block SHALL have port wb_we_i  input  1  1 = write, 0 = read.
REQ-010 The block SHALL have port wb_sel_i  input  4  byte-lane enables.
REQ-011 The block SHALL have port wb_stb_i  input  1  request strobe.
REQ-012 The block SHALL have port wb_ack_o  output  1  one-cycle response per accepted request.
REQ-013 The block SHALL have port wb_cyc_i  input  1  bus cycle active.
REQ-014 The block SHALL have port wb_stall_o  output  1  request not accepted this cycle.

Function
REQ-015 Acceptance SHALL occur at a rising edge where wb_cyc_i & wb_stb_i & !wb_stall_o; accepted adr, dat, we and sel SHALL be queued.
REQ-016 wb_stall_o SHALL equal (queue count == QUEUE_DEPTH), from registered count only; a same-cycle pop SHALL NOT unblock acceptance.
REQ-017 Each queue entry SHALL hold a wait counter loaded with LATENCY on acceptance and decremented each cycle to 0.
REQ-018 The head entry SHALL be serviced at the edge where its counter is 0; wb_ack_o SHALL be high the following cycle for exactly one cycle.
REQ-019 Request accepted at edge k SHALL be acked in cycle k+1+LATENCY when the queue ahead is empty; acks SHALL be strictly in acceptance order.
REQ-020 Back-to-back acceptances SHALL yield back-to-back acks (one per cycle) for any LATENCY.
REQ-021 Word index SHALL be wb_adr_i[log2(DEPTH)+1:2]; bits [1:0] and upper bits SHALL be ignored (address wraps modulo DEPTH*4).
REQ-022 Writes SHALL update only lanes with sel bit set, committed at service edge; sel = 0000 SHALL be acked with no memory change.
REQ-023 Reads SHALL return the full word, independent of sel, reflecting all writes serviced earlier.
REQ-024 wb_dat_o SHALL be 0 in cycles where wb_ack_o is 0 and for write acks.
REQ-025 Queue simultaneous push and pop SHALL keep count unchanged and both operations SHALL take effect.
REQ-026 wb_cyc_i low SHALL flush the queue at the next edge; unserviced writes SHALL be discarded, no further acks SHALL be issued, a request in its ack cycle SHALL complete.
REQ-027 wb_stb_i with wb_cyc_i low SHALL be ignored.

Reset
REQ-028 Asserting rst_i SHALL immediately force wb_ack_o = 0, wb_dat_o = 0, wb_stall_o = 0, queue empty, all wait counters 0.
REQ-029 Memory contents SHALL NOT be reset; reset mid-operation SHALL discard all queued, unserviced requests.
REQ-030 The first acceptance SHALL be possible at the first rising edge after rst_i deasserts.

Structure
REQ-031 Wishbone width constants (address 32, data 32, sel 4) SHALL live in ecap5_dproc_pkg; the queue entry struct SHALL be local to the module.
REQ-032 The request queue SHALL be a sub-module wb_req_queue (circular buffer, head/tail pointers, count, per-entry wait counter).

Verification
REQ-033 LATENCY=1: write adr 0x10 dat 0xDEADBEEF sel 1111, then read 0x10 -> acks at k+2 and k+3, read data 0xDEADBEEF.
REQ-034 Byte lanes: after 0x00000000 at 0x20, write 0x11223344 sel 0101, read 0x20 -> 0x00220044.
REQ-035 QUEUE_DEPTH=4, LATENCY=7: 6 consecutive stb -> stall high after 4th acceptance, 4 acks in order, remaining 2 accepted after drain, 6 acks total.
REQ-036 DEPTH=1024: write 0xA5A5A5A5 to 0x1000, read 0x0000 -> 0xA5A5A5A5 (wrap).
REQ-037 3 writes queued, LATENCY=3, drop wb_cyc_i one cycle after acceptance -> zero acks, read-back of targets returns prior values.
REQ-038 Assert rst_i with 2 reads outstanding -> wb_ack_o low immediately, no acks after release, stall 0.
